gmii_tx_scheduler: RTL and testbench

- Shares the GMII transmit interface (TXD/TX_EN/TX_ER) of the 1000BASE-X PCS transmit path between two byte-stream frame sources.
- Arbitrates at frame boundaries and inserts the preamble and SFD.
- Enforces a minimum inter-packet gap.
- Starts new frames only while the PCS reports xmit = DATA.
- Sits between the MAC-side frame sources and the PCS transmit/encoder block, in the GTX_CLK domain.

---
 rtl/gmii_tx_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_gmii_tx_scheduler.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_scheduler.sv
// gmii_tx_scheduler: shares the GMII transmit interface between two byte-stream
// frame sources. Arbitration happens at frame boundaries. The block inserts the
// preamble and SFD, flags underruns with TX_ER, and enforces a minimum IPG.
// Optional build macro: GMII_TX_SCHED_FIXED_PRIO_EN (source 0 wins on a tie).
module gmii_tx_scheduler #(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned IPG_LEN      = 12
) (
    input  logic       GTX_CLK,
    input  logic       mr_main_reset,
    input  logic       xmit,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [7:0] TXD,
    output logic       TX_EN,
    output logic       TX_ER,
    output logic [1:0] grant,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SFD,
        S_DATA,
        S_IPG
    } state_t;

    localparam logic [7:0] PRE_LOAD = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0] IPG_LOAD = 8'(IPG_LEN - 1);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic       r_last_seen, w_last_seen_nxt;
    logic [1:0] r_grant, w_grant_nxt;
    logic [7:0] r_txd, w_txd_nxt;
    logic       r_tx_en, w_tx_en_nxt;
    logic       r_tx_er, w_tx_er_nxt;
    logic       r_busy, w_busy_nxt;

    logic       w_accept_window;
    logic       w_sel_valid;
    logic [7:0] w_sel_data;
    logic       w_sel_last;
    logic       w_any_req;
    logic       w_win;

`ifndef GMII_TX_SCHED_FIXED_PRIO_EN
    logic       r_rr_ptr, w_rr_ptr_nxt;
`endif

    // The granted source may hand over a byte during SFD and during DATA until its last byte.
    assign w_accept_window = (r_state == S_SFD) || ((r_state == S_DATA) && !r_last_seen);
    assign req0_ready      = w_accept_window & r_grant[0];
    assign req1_ready      = w_accept_window & r_grant[1];

    assign w_sel_valid = r_grant[1] ? req1_valid : req0_valid;
    assign w_sel_data  = r_grant[1] ? req1_data  : req0_data;
    assign w_sel_last  = r_grant[1] ? req1_last  : req0_last;
    assign w_any_req   = req0_valid | req1_valid;

    // Winner index (0 or 1) for a new frame.
`ifdef GMII_TX_SCHED_FIXED_PRIO_EN
    assign w_win = ~req0_valid;
`else
    assign w_win = (req0_valid && req1_valid) ? r_rr_ptr : req1_valid;
`endif

    assign TXD   = r_txd;
    assign TX_EN = r_tx_en;
    assign TX_ER = r_tx_er;
    assign grant = r_grant;
    assign busy  = r_busy;

    assign w_busy_nxt = (w_state_nxt != S_IDLE);

    // Next-state and next-output logic; GMII outputs are computed one cycle ahead and registered.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_last_seen_nxt = r_last_seen;
        w_grant_nxt     = r_grant;
        w_txd_nxt       = 8'h00;
        w_tx_en_nxt     = 1'b0;
        w_tx_er_nxt     = 1'b0;
`ifndef GMII_TX_SCHED_FIXED_PRIO_EN
        w_rr_ptr_nxt    = r_rr_ptr;
`endif
        case (r_state)
            S_IDLE: begin
                w_grant_nxt = 2'b00;
                if (xmit && w_any_req) begin
                    w_state_nxt     = S_PRE;
                    w_cnt_nxt       = PRE_LOAD;
                    w_last_seen_nxt = 1'b0;
                    w_grant_nxt     = w_win ? 2'b10 : 2'b01;
                    w_tx_en_nxt     = 1'b1;
                    w_txd_nxt       = 8'h55;
`ifndef GMII_TX_SCHED_FIXED_PRIO_EN
                    w_rr_ptr_nxt    = ~w_win;
`endif
                end
            end
            S_PRE: begin
                w_tx_en_nxt = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = S_SFD;
                    w_txd_nxt   = 8'hD5;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                    w_txd_nxt = 8'h55;
                end
            end
            S_SFD, S_DATA: begin
                if (r_last_seen) begin
                    // Last byte is on the wire this cycle; the gap starts next.
                    w_state_nxt = S_IPG;
                    w_cnt_nxt   = IPG_LOAD;
                    w_grant_nxt = 2'b00;
                end else begin
                    w_state_nxt = S_DATA;
                    w_tx_en_nxt = 1'b1;
                    if (w_sel_valid) begin
                        w_txd_nxt       = w_sel_data;
                        w_last_seen_nxt = w_sel_last;
                    end else begin
                        w_tx_er_nxt = 1'b1;
                    end
                end
            end
            S_IPG: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    // State, counters and registered GMII outputs.
    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_last_seen <= 1'b0;
            r_grant     <= '0;
            r_txd       <= '0;
            r_tx_en     <= 1'b0;
            r_tx_er     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_last_seen <= w_last_seen_nxt;
            r_grant     <= w_grant_nxt;
            r_txd       <= w_txd_nxt;
            r_tx_en     <= w_tx_en_nxt;
            r_tx_er     <= w_tx_er_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

`ifndef GMII_TX_SCHED_FIXED_PRIO_EN
    // Round-robin pointer: index of the source favoured on the next tie.
    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            r_rr_ptr <= 1'b0;
        end else begin
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_gmii_tx_scheduler.sv
// Self-checking bench for gmii_tx_scheduler: random frames from two sources are
// checked against a frame-level model (preamble, SFD, bytes, underrun symbols,
// arbitration order, inter-frame gap).
module tb_gmii_tx_scheduler;

    localparam int P = 7;
    localparam int G = 12;

    typedef logic [8:0] sym_t;

    logic       GTX_CLK;
    logic       mr_main_reset;
    logic       xmit;
    logic       req0_valid, req0_last, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req1_data;
    logic [7:0] TXD;
    logic       TX_EN, TX_ER;
    logic [1:0] grant;
    logic       busy;

    gmii_tx_scheduler #(.PREAMBLE_LEN(P), .IPG_LEN(G)) dut (
        .GTX_CLK(GTX_CLK), .mr_main_reset(mr_main_reset), .xmit(xmit),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .TXD(TXD), .TX_EN(TX_EN), .TX_ER(TX_ER), .grant(grant), .busy(busy)
    );

    initial GTX_CLK = 1'b0;
    always #5 GTX_CLK = ~GTX_CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Source byte queues (what each source still has to hand over).
    logic [7:0] s0_data[$], s1_data[$];
    logic       s0_last[$], s1_last[$];
    int         s0_gap[$],  s1_gap[$];
    // Model: per-source expected frames, then the expected wire order.
    sym_t       m0_sym[$], m1_sym[$];
    int         m0_len[$], m1_len[$];
    int         m_last;
    sym_t       exp_sym[$];
    int         exp_len[$];
    logic [1:0] exp_grant[$];
    // Captured frames from the GMII side.
    sym_t       cap_sym[$];
    int         cap_len[$];
    logic [1:0] cap_grant[$];
    int         cap_gap[$];
    int         mon_bad;
    int         idle_run;
    bit         in_frame;
    // Frame builder.
    logic [7:0] fb_data[$];
    int         fb_gap[$];

    // Source 0 driver: valid/data held until accepted; gap = idle cycles before a byte.
    initial begin
        bit acc;
        req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
        forever begin
            @(negedge GTX_CLK); acc = req0_valid && req0_ready;
            @(posedge GTX_CLK); #1;
            if (acc && s0_data.size() > 0) begin
                void'(s0_data.pop_front()); void'(s0_last.pop_front()); void'(s0_gap.pop_front());
            end
            if (s0_data.size() == 0) req0_valid = 1'b0;
            else if (s0_gap[0] > 0) begin req0_valid = 1'b0; s0_gap[0] = s0_gap[0] - 1; end
            else begin req0_valid = 1'b1; req0_data = s0_data[0]; req0_last = s0_last[0]; end
        end
    end

    // Source 1 driver.
    initial begin
        bit acc;
        req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
        forever begin
            @(negedge GTX_CLK); acc = req1_valid && req1_ready;
            @(posedge GTX_CLK); #1;
            if (acc && s1_data.size() > 0) begin
                void'(s1_data.pop_front()); void'(s1_last.pop_front()); void'(s1_gap.pop_front());
            end
            if (s1_data.size() == 0) req1_valid = 1'b0;
            else if (s1_gap[0] > 0) begin req1_valid = 1'b0; s1_gap[0] = s1_gap[0] - 1; end
            else begin req1_valid = 1'b1; req1_data = s1_data[0]; req1_last = s1_last[0]; end
        end
    end

    // GMII monitor: collects frames (TX_EN runs) and flags protocol violations.
    initial begin
        sym_t cur[$];
        mon_bad = 0; idle_run = 0; in_frame = 1'b0;
        forever begin
            @(negedge GTX_CLK);
            if (!mr_main_reset) begin
                in_frame = 1'b0; idle_run = 0; cur.delete();
            end else begin
                if (req0_ready && req1_ready) mon_bad++;
                if (req0_ready && grant !== 2'b01) mon_bad++;
                if (req1_ready && grant !== 2'b10) mon_bad++;
                if (TX_EN) begin
                    if (!busy || grant == 2'b00) mon_bad++;
                    if (!in_frame) begin
                        in_frame = 1'b1;
                        cap_gap.push_back(idle_run);
                        cap_grant.push_back(grant);
                    end
                    cur.push_back({TX_ER, TXD});
                end else begin
                    if (in_frame) begin
                        in_frame = 1'b0;
                        foreach (cur[i]) cap_sym.push_back(cur[i]);
                        cap_len.push_back(cur.size());
                        cur.delete();
                        idle_run = 0;
                    end
                    idle_run++;
                    if (TX_ER !== 1'b0 || TXD !== 8'h00) mon_bad++;
                end
            end
        end
    end

    task automatic flush_all();
        s0_data.delete(); s0_last.delete(); s0_gap.delete();
        s1_data.delete(); s1_last.delete(); s1_gap.delete();
        m0_sym.delete(); m1_sym.delete(); m0_len.delete(); m1_len.delete();
        exp_sym.delete(); exp_len.delete(); exp_grant.delete();
        cap_sym.delete(); cap_len.delete(); cap_grant.delete(); cap_gap.delete();
        mon_bad = 0;
        m_last = 1;
    endtask

    task automatic do_reset();
        @(negedge GTX_CLK);
        mr_main_reset = 1'b0;
        flush_all();
        #12;
        mr_main_reset = 1'b1;
        @(negedge GTX_CLK);
    endtask

    // Hands the frame in fb_* to source s and records its expected wire image.
    task automatic push_frame(input int s);
        sym_t syms[$];
        for (int i = 0; i < P; i++) syms.push_back(9'h055);
        syms.push_back(9'h0D5);
        foreach (fb_data[i]) begin
            int g;
            g = (i == 0) ? 0 : fb_gap[i];
            for (int k = 0; k < g; k++) syms.push_back(9'h100);
            syms.push_back({1'b0, fb_data[i]});
            if (s == 0) begin
                s0_data.push_back(fb_data[i]); s0_last.push_back(i == fb_data.size() - 1); s0_gap.push_back(g);
            end else begin
                s1_data.push_back(fb_data[i]); s1_last.push_back(i == fb_data.size() - 1); s1_gap.push_back(g);
            end
        end
        if (s == 0) begin foreach (syms[i]) m0_sym.push_back(syms[i]); m0_len.push_back(syms.size()); end
        else begin foreach (syms[i]) m1_sym.push_back(syms[i]); m1_len.push_back(syms.size()); end
        fb_data.delete(); fb_gap.delete();
    endtask

    // Orders all pending frames the way the arbiter should send them.
    task automatic model_schedule();
        while (m0_len.size() > 0 || m1_len.size() > 0) begin
            int w, n;
            if (m0_len.size() > 0 && m1_len.size() > 0) begin
`ifdef GMII_TX_SCHED_FIXED_PRIO_EN
                w = 0;
`else
                w = (m_last == 0) ? 1 : 0;
`endif
            end else begin
                w = (m0_len.size() > 0) ? 0 : 1;
            end
            m_last = w;
            if (w == 0) begin
                n = m0_len.pop_front();
                for (int i = 0; i < n; i++) exp_sym.push_back(m0_sym.pop_front());
            end else begin
                n = m1_len.pop_front();
                for (int i = 0; i < n; i++) exp_sym.push_back(m1_sym.pop_front());
            end
            exp_len.push_back(n);
            exp_grant.push_back(w == 0 ? 2'b01 : 2'b10);
        end
    endtask

    task automatic random_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            fb_data.push_back(8'($urandom_range(0, 255)));
            fb_gap.push_back(0);
        end
    endtask

    task automatic test_reset();
        mr_main_reset = 1'b1; xmit = 1'b0;
        #2 mr_main_reset = 1'b0;
        flush_all();
        #1;
        n_checks++;
        if ({TXD, TX_EN, TX_ER, grant, busy, req0_ready, req1_ready} !== '0) begin
            n_fail++; $display("FAIL reset.outputs: got %h expected 0", {TXD, TX_EN, TX_ER, grant, busy, req0_ready, req1_ready});
        end
        #11 mr_main_reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge GTX_CLK);
            n_checks++;
            if ({TXD, TX_EN, TX_ER, grant, busy, req0_ready, req1_ready} !== '0) begin
                n_fail++; $display("FAIL reset.idle cycle %0d: got %h expected 0", c, {TXD, TX_EN, TX_ER, grant, busy, req0_ready, req1_ready});
            end
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        xmit = 1'b1;
        fb_data = '{8'hC5, 8'h00, 8'hC5, 8'h07, 8'hC5}; fb_gap = '{0, 0, 0, 0, 0};
        push_frame(0);
        model_schedule();
        for (int c = 0; c < 100 && cap_len.size() < 1; c++) @(negedge GTX_CLK);
        repeat (G) @(negedge GTX_CLK);
        n_checks++;
        if (cap_len.size() !== 1) begin n_fail++; $display("FAIL single.frames: got %0d expected 1", cap_len.size()); end
        else begin
            n_checks++;
            if (cap_len[0] !== P + 1 + 5) begin n_fail++; $display("FAIL single.tx_en_len: got %0d expected %0d", cap_len[0], P + 6); end
            n_checks++;
            if (cap_grant[0] !== 2'b01) begin n_fail++; $display("FAIL single.grant: got %b expected 01", cap_grant[0]); end
            foreach (exp_sym[i]) begin
                n_checks++;
                if (i >= cap_sym.size() || cap_sym[i] !== exp_sym[i]) begin
                    n_fail++; $display("FAIL single.sym[%0d]: got %h expected %h", i, cap_sym[i], exp_sym[i]);
                end
            end
        end
        n_checks++;
        if (idle_run < G || mon_bad !== 0) begin n_fail++; $display("FAIL single.ipg: idle %0d bad %0d, required idle>=%0d bad 0", idle_run, mon_bad, G); end
    endtask

    task automatic test_arbitration();
        do_reset();
        xmit = 1'b0;
        fb_data = '{8'hA1, 8'hA2, 8'hA3}; fb_gap = '{0, 0, 0}; push_frame(0);
        fb_data = '{8'hB1, 8'hB2, 8'hB3}; fb_gap = '{0, 0, 0}; push_frame(1);
        random_bytes(3); push_frame(0);
        random_bytes(3); push_frame(1);
        model_schedule();
        repeat (3) @(negedge GTX_CLK);
        xmit = 1'b1;
        for (int c = 0; c < 400 && cap_len.size() < 4; c++) @(negedge GTX_CLK);
        n_checks++;
        if (cap_len.size() !== exp_len.size()) begin n_fail++; $display("FAIL arb.frames: got %0d expected %0d", cap_len.size(), exp_len.size()); end
        else begin
            foreach (exp_len[f]) begin
                n_checks++;
                if (cap_grant[f] !== exp_grant[f]) begin n_fail++; $display("FAIL arb.grant[%0d]: got %b expected %b", f, cap_grant[f], exp_grant[f]); end
                n_checks++;
                if (cap_len[f] !== exp_len[f]) begin n_fail++; $display("FAIL arb.len[%0d]: got %0d expected %0d", f, cap_len[f], exp_len[f]); end
                if (f > 0) begin
                    n_checks++;
                    if (cap_gap[f] !== G + 1) begin n_fail++; $display("FAIL arb.gap[%0d]: got %0d expected %0d", f, cap_gap[f], G + 1); end
                end
            end
            foreach (exp_sym[i]) begin
                n_checks++;
                if (i >= cap_sym.size() || cap_sym[i] !== exp_sym[i]) begin
                    n_fail++; $display("FAIL arb.sym[%0d]: got %h expected %h", i, cap_sym[i], exp_sym[i]);
                end
            end
        end
        n_checks++;
        if (mon_bad !== 0) begin n_fail++; $display("FAIL arb.protocol: got %0d violations expected 0", mon_bad); end
    endtask

    task automatic test_underrun();
        int ers;
        do_reset();
        xmit = 1'b1;
        random_bytes(5);
        fb_gap[2] = 2;
        push_frame(1);
        model_schedule();
        for (int c = 0; c < 100 && cap_len.size() < 1; c++) @(negedge GTX_CLK);
        n_checks++;
        if (cap_len.size() !== 1) begin n_fail++; $display("FAIL underrun.frames: got %0d expected 1", cap_len.size()); end
        else begin
            n_checks++;
            if (cap_grant[0] !== 2'b10) begin n_fail++; $display("FAIL underrun.grant: got %b expected 10", cap_grant[0]); end
            ers = 0;
            foreach (cap_sym[i]) if (cap_sym[i][8]) ers++;
            n_checks++;
            if (ers !== 2) begin n_fail++; $display("FAIL underrun.er_count: got %0d expected 2", ers); end
            foreach (exp_sym[i]) begin
                n_checks++;
                if (i >= cap_sym.size() || cap_sym[i] !== exp_sym[i]) begin
                    n_fail++; $display("FAIL underrun.sym[%0d]: got %h expected %h", i, cap_sym[i], exp_sym[i]);
                end
            end
        end
    endtask

    task automatic test_xmit_gating();
        int c;
        do_reset();
        xmit = 1'b0;
        random_bytes(6); push_frame(0);
        model_schedule();
        repeat (50) @(negedge GTX_CLK);
        n_checks++;
        if (cap_len.size() !== 0 || in_frame) begin n_fail++; $display("FAIL xmit.blocked: got %0d frames expected 0", cap_len.size() + int'(in_frame)); end
        @(posedge GTX_CLK); #1 xmit = 1'b1;
        c = 0;
        while (!TX_EN && c < 2) begin @(negedge GTX_CLK); c++; end
        n_checks++;
        if (TX_EN !== 1'b1) begin n_fail++; $display("FAIL xmit.start: TX_EN %b after %0d cycles, expected 1", TX_EN, c); end
        repeat (P + 3) @(negedge GTX_CLK);
        xmit = 1'b0;
        for (int k = 0; k < 100 && cap_len.size() < 1; k++) @(negedge GTX_CLK);
        random_bytes(4); push_frame(0);
        model_schedule();
        repeat (40) @(negedge GTX_CLK);
        n_checks++;
        if (cap_len.size() !== 1 || in_frame) begin n_fail++; $display("FAIL xmit.drop: got %0d frames expected 1", cap_len.size() + int'(in_frame)); end
        xmit = 1'b1;
        for (int k = 0; k < 100 && cap_len.size() < 2; k++) @(negedge GTX_CLK);
        n_checks++;
        if (cap_len.size() !== 2) begin n_fail++; $display("FAIL xmit.frames: got %0d expected 2", cap_len.size()); end
        else begin
            n_checks++;
            if (cap_gap[1] < G + 1) begin n_fail++; $display("FAIL xmit.gap: got %0d expected >= %0d", cap_gap[1], G + 1); end
            foreach (exp_sym[i]) begin
                n_checks++;
                if (i >= cap_sym.size() || cap_sym[i] !== exp_sym[i]) begin
                    n_fail++; $display("FAIL xmit.sym[%0d]: got %h expected %h", i, cap_sym[i], exp_sym[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        xmit = 1'b1;
        random_bytes(10); push_frame(0);
        for (int c = 0; c < 20 && !TX_EN; c++) @(negedge GTX_CLK);
        repeat (P + 3) @(negedge GTX_CLK);
        n_checks++;
        if (req0_ready !== 1'b1 || TX_EN !== 1'b1) begin n_fail++; $display("FAIL midreset.in_data: ready %b tx_en %b expected 1 1", req0_ready, TX_EN); end
        #2 mr_main_reset = 1'b0;
        #1;
        n_checks++;
        if (TX_EN !== 1'b0) begin n_fail++; $display("FAIL midreset.tx_en: got %b expected 0", TX_EN); end
        n_checks++;
        if (grant !== 2'b00) begin n_fail++; $display("FAIL midreset.grant: got %b expected 00", grant); end
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL midreset.ready: got %b expected 00", {req0_ready, req1_ready}); end
        n_checks++;
        if ({TXD, TX_ER, busy} !== '0) begin n_fail++; $display("FAIL midreset.txd_er_busy: got %h expected 0", {TXD, TX_ER, busy}); end
        flush_all();
        repeat (2) @(negedge GTX_CLK);
        #2 mr_main_reset = 1'b1;
        repeat (20) @(negedge GTX_CLK);
        n_checks++;
        if (cap_len.size() !== 0 || in_frame) begin n_fail++; $display("FAIL midreset.quiet: got %0d frames expected 0", cap_len.size() + int'(in_frame)); end
        random_bytes(3); push_frame(1);
        model_schedule();
        for (int c = 0; c < 100 && cap_len.size() < 1; c++) @(negedge GTX_CLK);
        n_checks++;
        if (cap_len.size() !== 1 || cap_grant[0] !== 2'b10) begin n_fail++; $display("FAIL midreset.restart: got %0d frames expected 1 with grant 10", cap_len.size()); end
        else begin
            foreach (exp_sym[i]) begin
                n_checks++;
                if (i >= cap_sym.size() || cap_sym[i] !== exp_sym[i]) begin
                    n_fail++; $display("FAIL midreset.sym[%0d]: got %h expected %h", i, cap_sym[i], exp_sym[i]);
                end
            end
        end
    endtask

    task automatic test_random_frames();
        do_reset();
        xmit = 1'b1;
        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(1, 8);
            random_bytes(n);
            for (int i = 1; i < n; i++) fb_gap[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            push_frame($urandom_range(0, 1));
        end
        model_schedule();
        for (int c = 0; c < 1500 && cap_len.size() < 8; c++) @(negedge GTX_CLK);
        n_checks++;
        if (cap_len.size() !== exp_len.size()) begin n_fail++; $display("FAIL random.frames: got %0d expected %0d", cap_len.size(), exp_len.size()); end
        else begin
            foreach (exp_len[f]) begin
                n_checks++;
                if (cap_grant[f] !== exp_grant[f] || cap_len[f] !== exp_len[f]) begin
                    n_fail++; $display("FAIL random.frame[%0d]: got grant %b len %0d expected grant %b len %0d", f, cap_grant[f], cap_len[f], exp_grant[f], exp_len[f]);
                end
                if (f > 0) begin
                    n_checks++;
                    if (cap_gap[f] < G + 1) begin n_fail++; $display("FAIL random.gap[%0d]: got %0d expected >= %0d", f, cap_gap[f], G + 1); end
                end
            end
            foreach (exp_sym[i]) begin
                n_checks++;
                if (i >= cap_sym.size() || cap_sym[i] !== exp_sym[i]) begin
                    n_fail++; $display("FAIL random.sym[%0d]: got %h expected %h", i, cap_sym[i], exp_sym[i]);
                end
            end
        end
        n_checks++;
        if (mon_bad !== 0) begin n_fail++; $display("FAIL random.protocol: got %0d violations expected 0", mon_bad); end
    endtask

    initial begin
        mr_main_reset = 1'b1;
        xmit = 1'b0;
        m_last = 1;
        test_reset();
        test_single_frame();
        test_arbitration();
        test_underrun();
        test_xmit_gating();
        test_reset_midframe();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
